// File: rtl/rx_iq_mf.sv
// rx_iq_mf: dual-channel (I/Q) QPSK matched filter with registered accumulators and symbol-rate hard decisions.
// Soft outputs (saturated acc >>> COEF_FBITS) are built only when RX_IQ_MF_SOFT_OUT_EN is defined.
module rx_iq_mf #(
  parameter int UPSAMPLE   = 4,
  parameter int NCOEF      = 24,
  parameter int COEF_NBITS = 8,
  parameter int COEF_FBITS = 7,
  parameter int DATA_NBITS = 8,
  parameter int SOFT_NBITS = 8,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0,
  localparam int PH_NBITS  = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic signed [DATA_NBITS-1:0] rx_i_in,
  input  logic signed [DATA_NBITS-1:0] rx_q_in,
  input  logic        [PH_NBITS-1:0]   phase_in,
  output logic                         sym_i_out,
  output logic                         sym_q_out,
  output logic                         sym_valid
`ifdef RX_IQ_MF_SOFT_OUT_EN
  ,
  output logic signed [SOFT_NBITS-1:0] soft_i_out,
  output logic signed [SOFT_NBITS-1:0] soft_q_out
`endif
);

  localparam int PROD_NBITS = DATA_NBITS + COEF_NBITS;
  localparam int ACC_NBITS  = DATA_NBITS + COEF_NBITS + $clog2(NCOEF);
  localparam logic signed [ACC_NBITS-1:0] ACC_ZERO = '0;
  // Misconfigured builds (too few samples per symbol, bad soft format) never emit decisions.
  localparam bit CFG_OK = (UPSAMPLE >= 2) && (SOFT_NBITS >= 2) &&
                          (COEF_FBITS >= 0) && (COEF_FBITS < ACC_NBITS);

  logic signed [COEF_NBITS-1:0] coef     [NCOEF];
  logic signed [DATA_NBITS-1:0] tap_in_i [NCOEF];
  logic signed [DATA_NBITS-1:0] tap_in_q [NCOEF];
  logic signed [DATA_NBITS-1:0] buf_i_q  [NCOEF];
  logic signed [DATA_NBITS-1:0] buf_q_q  [NCOEF];
  logic signed [PROD_NBITS-1:0] prod_i   [NCOEF];
  logic signed [PROD_NBITS-1:0] prod_q   [NCOEF];

  logic signed [ACC_NBITS-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_NBITS-1:0] acc_q_q, acc_q_d;
  logic        [PH_NBITS-1:0]  cnt_q, cnt_d;
  logic                        sym_i_q, sym_q_q, sym_valid_q;
  logic                        decide;

  genvar gi;
  generate
    for (gi = 0; gi < NCOEF; gi++) begin : g_tap
      // Tap 0 sits in the MSBs of COEF and multiplies the newest sample.
      assign coef[gi] = COEF[(NCOEF-1-gi)*COEF_NBITS +: COEF_NBITS];
      if (gi == 0) begin : g_head
        assign tap_in_i[gi] = rx_i_in;
        assign tap_in_q[gi] = rx_q_in;
      end else begin : g_body
        assign tap_in_i[gi] = buf_i_q[gi-1];
        assign tap_in_q[gi] = buf_q_q[gi-1];
      end
      assign prod_i[gi] = PROD_NBITS'(buf_i_q[gi]) * PROD_NBITS'(coef[gi]);
      assign prod_q[gi] = PROD_NBITS'(buf_q_q[gi]) * PROD_NBITS'(coef[gi]);
    end
  endgenerate

  always_comb begin
    acc_i_d = '0;
    acc_q_d = '0;
    for (int i = 0; i < NCOEF; i++) begin
      acc_i_d = acc_i_d + ACC_NBITS'(prod_i[i]);
      acc_q_d = acc_q_d + ACC_NBITS'(prod_q[i]);
    end
  end

  assign cnt_d  = (cnt_q == PH_NBITS'(UPSAMPLE - 1)) ? '0 : cnt_q + PH_NBITS'(1);
  assign decide = enable && CFG_OK && (cnt_q == phase_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        buf_i_q[i] <= '0;
        buf_q_q[i] <= '0;
      end
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      sym_i_q     <= 1'b0;
      sym_q_q     <= 1'b0;
      sym_valid_q <= 1'b0;
    end else begin
      sym_valid_q <= decide;
      if (enable) begin
        for (int i = 0; i < NCOEF; i++) begin
          buf_i_q[i] <= tap_in_i[i];
          buf_q_q[i] <= tap_in_q[i];
        end
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
        cnt_q   <= cnt_d;
      end
      // Sign test on the full word; a zero accumulator decides as 1.
      if (decide) begin
        sym_i_q <= (acc_i_q >= ACC_ZERO);
        sym_q_q <= (acc_q_q >= ACC_ZERO);
      end
    end
  end

  assign sym_i_out = sym_i_q;
  assign sym_q_out = sym_q_q;
  assign sym_valid = sym_valid_q;

`ifdef RX_IQ_MF_SOFT_OUT_EN
  localparam logic signed [ACC_NBITS-1:0] SOFT_MAX = ACC_NBITS'((1 <<< (SOFT_NBITS - 1)) - 1);
  localparam logic signed [ACC_NBITS-1:0] SOFT_MIN = ACC_NBITS'(-(1 <<< (SOFT_NBITS - 1)));

  logic signed [SOFT_NBITS-1:0] soft_i_q, soft_q_q;

  function automatic logic signed [SOFT_NBITS-1:0] sat_soft(input logic signed [ACC_NBITS-1:0] a);
    logic signed [ACC_NBITS-1:0] sh;
    sh = a >>> COEF_FBITS;
    if (sh > SOFT_MAX)      return SOFT_MAX[SOFT_NBITS-1:0];
    else if (sh < SOFT_MIN) return SOFT_MIN[SOFT_NBITS-1:0];
    else                    return sh[SOFT_NBITS-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      soft_i_q <= '0;
      soft_q_q <= '0;
    end else if (decide) begin
      soft_i_q <= sat_soft(acc_i_q);
      soft_q_q <= sat_soft(acc_q_q);
    end
  end

  assign soft_i_out = soft_i_q;
  assign soft_q_out = soft_q_q;
`endif

endmodule

// File: tb/tb_rx_iq_mf.sv
// Scoreboard bench for rx_iq_mf: two instances (UPSAMPLE=4 with taps {10,20,30,40}, UPSAMPLE=6 with all taps 127).
// Expected decisions are hand-computed, queued with the edge on which sym_valid must appear.
module tb_rx_iq_mf;

  typedef struct {
    int   edge_no;
    logic si;
    logic sq;
    int   soi;
    int   soq;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int passes = 0;

  exp_t qa[$];
  exp_t qb[$];

  logic              a_rst, a_en, a_si, a_sq, a_vld;
  logic signed [7:0] a_rxi, a_rxq;
  logic        [1:0] a_ph;
  logic              b_rst, b_en, b_si, b_sq, b_vld;
  logic signed [7:0] b_rxi, b_rxq;
  logic        [2:0] b_ph;
`ifdef RX_IQ_MF_SOFT_OUT_EN
  logic signed [7:0] a_soi, a_soq, b_soi, b_soq;
`endif

  rx_iq_mf #(
    .UPSAMPLE(4), .NCOEF(4), .COEF_NBITS(8), .COEF_FBITS(7), .DATA_NBITS(8), .SOFT_NBITS(8),
    .COEF({8'sd10, 8'sd20, 8'sd30, 8'sd40})
  ) u_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .rx_i_in(a_rxi), .rx_q_in(a_rxq), .phase_in(a_ph),
    .sym_i_out(a_si), .sym_q_out(a_sq), .sym_valid(a_vld)
`ifdef RX_IQ_MF_SOFT_OUT_EN
    , .soft_i_out(a_soi), .soft_q_out(a_soq)
`endif
  );

  rx_iq_mf #(
    .UPSAMPLE(6), .NCOEF(4), .COEF_NBITS(8), .COEF_FBITS(7), .DATA_NBITS(8), .SOFT_NBITS(8),
    .COEF({4{8'sd127}})
  ) u_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .rx_i_in(b_rxi), .rx_q_in(b_rxq), .phase_in(b_ph),
    .sym_i_out(b_si), .sym_q_out(b_sq), .sym_valid(b_vld)
`ifdef RX_IQ_MF_SOFT_OUT_EN
    , .soft_i_out(b_soi), .soft_q_out(b_soq)
`endif
  );

  task automatic chk(input string name, input int e, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s edge=%0d got=%0d exp=%0d", name, e, act, exp);
  endtask

  // Monitors: compare on every sym_valid, and flag expected pulses whose edge passed unseen.
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].edge_no < edge_cnt) begin
      checks++;
      $display("FAIL a_missing_valid edge=%0d got=0 exp=1", qa[0].edge_no);
      void'(qa.pop_front());
    end
    if (a_vld === 1'b1) begin
      if (qa.size() == 0 || qa[0].edge_no != edge_cnt) begin
        checks++;
        $display("FAIL a_unexpected_valid edge=%0d got=1 exp=0", edge_cnt);
      end else begin
        exp_t x;
        x = qa.pop_front();
        chk("a_sym_i", edge_cnt, int'(a_si), int'(x.si));
        chk("a_sym_q", edge_cnt, int'(a_sq), int'(x.sq));
`ifdef RX_IQ_MF_SOFT_OUT_EN
        chk("a_soft_i", edge_cnt, int'(a_soi), x.soi);
        chk("a_soft_q", edge_cnt, int'(a_soq), x.soq);
`endif
        $display("a edge=%0d sym_i=%0d sym_q=%0d", edge_cnt, a_si, a_sq);
      end
    end
  end

  always @(negedge clk) begin
    while (qb.size() > 0 && qb[0].edge_no < edge_cnt) begin
      checks++;
      $display("FAIL b_missing_valid edge=%0d got=0 exp=1", qb[0].edge_no);
      void'(qb.pop_front());
    end
    if (b_vld === 1'b1) begin
      if (qb.size() == 0 || qb[0].edge_no != edge_cnt) begin
        checks++;
        $display("FAIL b_unexpected_valid edge=%0d got=1 exp=0", edge_cnt);
      end else begin
        exp_t x;
        x = qb.pop_front();
        chk("b_sym_i", edge_cnt, int'(b_si), int'(x.si));
        chk("b_sym_q", edge_cnt, int'(b_sq), int'(x.sq));
`ifdef RX_IQ_MF_SOFT_OUT_EN
        chk("b_soft_i", edge_cnt, int'(b_soi), x.soi);
        chk("b_soft_q", edge_cnt, int'(b_soq), x.soq);
`endif
        $display("b edge=%0d sym_i=%0d sym_q=%0d", edge_cnt, b_si, b_sq);
      end
    end
  end

  task automatic push_a(input logic si, input logic sq, input int soi, input int soq);
    qa.push_back('{edge_cnt + 1, si, sq, soi, soq});
  endtask

  task automatic push_b(input logic si, input logic sq, input int soi, input int soq);
    qb.push_back('{edge_cnt + 1, si, sq, soi, soq});
  endtask

  task automatic step_a(input logic en, input int i, input int q, input int ph);
    a_en = en; a_rxi = 8'(i); a_rxq = 8'(q); a_ph = 2'(ph);
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic en, input int i, input int q, input int ph);
    b_en = en; b_rxi = 8'(i); b_rxq = 8'(q); b_ph = 3'(ph);
    @(posedge clk); #1;
  endtask

  task automatic chk_a_cleared(input string tag);
    chk({tag, "_sym_i"}, edge_cnt, int'(a_si), 0);
    chk({tag, "_sym_q"}, edge_cnt, int'(a_sq), 0);
    chk({tag, "_valid"}, edge_cnt, int'(a_vld), 0);
`ifdef RX_IQ_MF_SOFT_OUT_EN
    chk({tag, "_soft_i"}, edge_cnt, int'(a_soi), 0);
    chk({tag, "_soft_q"}, edge_cnt, int'(a_soq), 0);
`endif
  endtask

  // Impulse response seen through a phase that tracks the counter (a decision every edge).
  int a2_soi [7] = '{0, 0, 7, 15, 23, 31, 0};
  int a2_soq [7] = '{0, 0, -8, -16, -24, -32, 0};
  // UPSAMPLE=6: phase 3 decides at cnt==3, then phase 5 gives one short interval (40 -> 42).
  int b_dec  [9] = '{4, 10, 16, 22, 28, 34, 40, 42, 48};

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_rxi = '0; a_rxq = '0; a_ph = '0;
    b_rst = 1'b1; b_en = 1'b0; b_rxi = '0; b_rxq = '0; b_ph = 3'd3;
    @(posedge clk); #1;
    chk_a_cleared("a_init");
    chk("b_init_sym_i", edge_cnt, int'(b_si), 0);
    chk("b_init_valid", edge_cnt, int'(b_vld), 0);
    a_rst = 1'b0; b_rst = 1'b0;

    // Constant I=-16, Q=+16: acc ramps -160,-480,-960 then settles at -1600.
    for (int k = 1; k <= 13; k++) begin
      if (k == 1)                 push_a(1'b1, 1'b1, 0, 0);
      else if (k == 5)            push_a(1'b0, 1'b1, -8, 7);
      else if (k == 9 || k == 13) push_a(1'b0, 1'b1, -13, 12);
      step_a(1'b1, -16, 16, 0);
    end

    // Reset mid-symbol with enable high: reset wins and history is discarded.
    a_rst = 1'b1;
    step_a(1'b1, 55, -55, 0);
    a_rst = 1'b0;
    chk_a_cleared("a_midrst");

    for (int k = 1; k <= 7; k++) begin
      push_a(1'b1, (k >= 3 && k <= 6) ? 1'b0 : 1'b1, a2_soi[k-1], a2_soq[k-1]);
      step_a(1'b1, (k == 1) ? 100 : 0, (k == 1) ? -100 : 0, (k - 1) % 4);
    end

    a_rst = 1'b1;
    step_a(1'b0, 0, 0, 0);
    a_rst = 1'b0;
    chk_a_cleared("a_rst2");

    // Enable alternates; disabled cycles carry junk that must not enter the buffer.
    for (int k = 1; k <= 9; k++) begin
      if (k == 1)      push_a(1'b1, 1'b1, 0, 0);
      else if (k == 5) push_a(1'b0, 1'b1, -8, 7);
      else if (k == 9) push_a(1'b0, 1'b1, -13, 12);
      step_a(1'b1, -16, 16, 0);
      step_a(1'b0, 50, -50, 0);
    end
    repeat (3) step_a(1'b0, -100, 100, 0);
    chk("a_hold_sym_i", edge_cnt, int'(a_si), 0);
    chk("a_hold_sym_q", edge_cnt, int'(a_sq), 1);
    chk("a_hold_valid", edge_cnt, int'(a_vld), 0);

    // Saturating inputs; phase 6 is out of range and must never fire.
    for (int k = 1; k <= 62; k++) begin
      for (int j = 0; j < 9; j++)
        if (b_dec[j] == k) push_b(1'b1, 1'b0, 127, -128);
      step_b(1'b1, (k <= 50) ? 127 : -128, (k <= 50) ? -128 : 127,
             (k <= 40) ? 3 : ((k <= 50) ? 5 : 6));
    end
    chk("b_hold_sym_i", edge_cnt, int'(b_si), 1);
    chk("b_hold_sym_q", edge_cnt, int'(b_sq), 0);
    for (int k = 63; k <= 68; k++) begin
      if (k == 67) push_b(1'b0, 1'b1, -128, 127);
      step_b(1'b1, -128, 127, 0);
    end
    step_b(1'b0, 0, 0, 0);
    step_b(1'b0, 0, 0, 0);

    @(negedge clk); #1;
    while (qa.size() > 0) begin
      checks++;
      $display("FAIL a_pending edge=%0d got=0 exp=1", qa[0].edge_no);
      void'(qa.pop_front());
    end
    while (qb.size() > 0) begin
      checks++;
      $display("FAIL b_pending edge=%0d got=0 exp=1", qb[0].edge_no);
      void'(qb.pop_front());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
